// File: rtl/spi_txn_arbiter.sv
// Round-robin sequencer sharing one APB-style SPI master register port among four requesters.
// Each grant runs CONFIG/TX/CMD writes, polls STATE until idle or timeout, then reads RX back.
module spi_txn_arbiter #(
  parameter int unsigned SETTLE_CYC   = 2,
  parameter int unsigned POLL_TIMEOUT = 255,
  parameter logic [7:0]  CMD_START    = 8'h01
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [3:0]  req,
  input  logic [31:0] req_cfg,
  input  logic [31:0] req_tx,
  output logic [3:0]  grant,
  output logic [3:0]  done,
  output logic        err,
  output logic [7:0]  rx_data,
  output logic        o_WR0,
  output logic        o_WR1,
  output logic        o_WR2,
  output logic        o_WR3,
  output logic        o_DR0,
  output logic        o_DR1,
  output logic        o_DR2,
  output logic        o_DR3,
  output logic [7:0]  o_PWDATA,
  input  logic [7:0]  i_PRDATA
);

  typedef enum logic [3:0] {
    IDLE, CFG, TX, CMD, SETTLE, POLL, POLL_GAP, READ, DONE
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  g_idx, g_nxt, rr_ptr, rr_nxt, pick;
  logic        found;
  logic [7:0]  cfg_q, cfg_nxt, tx_q, tx_nxt;
  logic [3:0]  settle_cnt, settle_nxt;
  logic [7:0]  poll_cnt, poll_nxt, poll_inc;
  logic        err_flag, err_flag_nxt;
  logic [7:0]  rx_nxt, pwdata_nxt;
  logic [3:0]  grant_nxt, done_nxt, g_onehot;
  logic        err_nxt, wr0_nxt, wr1_nxt, wr3_nxt, dr0_nxt, dr1_nxt;

  assign o_WR2 = 1'b0;
  assign o_DR2 = 1'b0;
  assign o_DR3 = 1'b0;

  // Search starts one past the last served requester, wrapping modulo 4.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    for (int unsigned k = 1; k <= 4; k++) begin
      if (!found && req[2'(rr_ptr + 2'(k))]) begin
        found = 1'b1;
        pick  = 2'(rr_ptr + 2'(k));
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    g_nxt        = g_idx;
    rr_nxt       = rr_ptr;
    cfg_nxt      = cfg_q;
    tx_nxt       = tx_q;
    settle_nxt   = settle_cnt;
    poll_nxt     = poll_cnt;
    poll_inc     = poll_cnt + 8'd1;
    err_flag_nxt = err_flag;
    rx_nxt       = rx_data;
    case (state)
      IDLE: begin
        if (found) begin
          g_nxt     = pick;
          cfg_nxt   = req_cfg[{pick, 3'b000} +: 8];
          tx_nxt    = req_tx[{pick, 3'b000} +: 8];
          state_nxt = CFG;
        end
      end
      CFG: state_nxt = TX;
      TX:  state_nxt = CMD;
      CMD: begin
        settle_nxt = 4'(SETTLE_CYC - 1);
        state_nxt  = SETTLE;
      end
      SETTLE: begin
        if (settle_cnt == '0) state_nxt = POLL;
        else                  settle_nxt = settle_cnt - 4'd1;
      end
      POLL: begin
        poll_nxt = poll_inc;
        if (!i_PRDATA[0]) begin
          state_nxt = READ;
        end else if (poll_inc == 8'(POLL_TIMEOUT)) begin
          err_flag_nxt = 1'b1;
          state_nxt    = DONE;
        end else begin
          state_nxt = POLL_GAP;
        end
      end
      POLL_GAP: state_nxt = POLL;
      READ: begin
        rx_nxt    = i_PRDATA;
        state_nxt = DONE;
      end
      DONE: begin
        rr_nxt       = g_idx;
        poll_nxt     = '0;
        err_flag_nxt = 1'b0;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Outputs are decoded from the next state so the registered copy lines up with the state.
    g_onehot  = 4'b0001 << g_nxt;
    wr0_nxt   = (state_nxt == CFG);
    wr1_nxt   = (state_nxt == TX);
    wr3_nxt   = (state_nxt == CMD);
    dr0_nxt   = (state_nxt == POLL);
    dr1_nxt   = (state_nxt == READ);
    grant_nxt = (state_nxt inside {CFG, TX, CMD, SETTLE, POLL, POLL_GAP, READ}) ? g_onehot : '0;
    done_nxt  = (state_nxt == DONE) ? g_onehot : '0;
    err_nxt   = (state_nxt == DONE) && err_flag_nxt;
    case (state_nxt)
      CFG:     pwdata_nxt = cfg_nxt;
      TX:      pwdata_nxt = tx_nxt;
      CMD:     pwdata_nxt = CMD_START;
      default: pwdata_nxt = '0;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state      <= IDLE;
      g_idx      <= '0;
      rr_ptr     <= 2'd3;
      cfg_q      <= '0;
      tx_q       <= '0;
      settle_cnt <= '0;
      poll_cnt   <= '0;
      err_flag   <= 1'b0;
      rx_data    <= '0;
      grant      <= '0;
      done       <= '0;
      err        <= 1'b0;
      o_WR0      <= 1'b0;
      o_WR1      <= 1'b0;
      o_WR3      <= 1'b0;
      o_DR0      <= 1'b0;
      o_DR1      <= 1'b0;
      o_PWDATA   <= '0;
    end else begin
      state      <= state_nxt;
      g_idx      <= g_nxt;
      rr_ptr     <= rr_nxt;
      cfg_q      <= cfg_nxt;
      tx_q       <= tx_nxt;
      settle_cnt <= settle_nxt;
      poll_cnt   <= poll_nxt;
      err_flag   <= err_flag_nxt;
      rx_data    <= rx_nxt;
      grant      <= grant_nxt;
      done       <= done_nxt;
      err        <= err_nxt;
      o_WR0      <= wr0_nxt;
      o_WR1      <= wr1_nxt;
      o_WR3      <= wr3_nxt;
      o_DR0      <= dr0_nxt;
      o_DR1      <= dr1_nxt;
      o_PWDATA   <= pwdata_nxt;
    end
  end

endmodule
